// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and constants for the two-port data memory arbiter.
package arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RD   = 1'b1
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    localparam int unsigned DW_DEFAULT = 16;
    localparam int unsigned AW_DEFAULT = 12;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Requester ports and memory port of the data memory arbiter, bundled as one interface.
interface data_mem_arbiter_if
    import arb_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT,
    parameter int unsigned AW = AW_DEFAULT
) ();

    logic          Rd0, Wr0, Waitreq0;
    logic [AW-1:0] Addr0;
    logic [DW-1:0] WrData0, RdData0;

    logic          Rd1, Wr1, Waitreq1;
    logic [AW-1:0] Addr1;
    logic [DW-1:0] WrData1, RdData1;

    logic [AW-1:0] MemAddr;
    logic [DW-1:0] MemWrData, MemRdData;
    logic          MemWren;

    modport slave (
        input  Rd0, Wr0, Addr0, WrData0, Rd1, Wr1, Addr1, WrData1, MemRdData,
        output RdData0, Waitreq0, RdData1, Waitreq1, MemAddr, MemWrData, MemWren
    );

    modport master (
        output Rd0, Wr0, Addr0, WrData0, Rd1, Wr1, Addr1, WrData1, MemRdData,
        input  RdData0, Waitreq0, RdData1, Waitreq1, MemAddr, MemWrData, MemWren
    );

endinterface

// File: rtl/data_mem_arbiter_pick.sv
// Winner select between the two requesters. ARB_ROUND_ROBIN_EN selects round robin,
// otherwise port 0 has fixed priority.
module arb_pick (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic any,
    output logic winner
);

    assign any = req0 | req1;

`ifdef ARB_ROUND_ROBIN_EN
    // On contention the port that did not win last time goes first.
    assign winner = (req0 && req1) ? ~last : req1;
`else
    logic unused_last;
    assign unused_last = last;
    assign winner      = req1 & ~req0;
`endif

endmodule

// File: rtl/data_mem_arbiter.sv
// Serialises two waitrequest-style requesters onto one registered-read memory.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is port 0 priority.
module data_mem_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT,
    parameter int unsigned AW = AW_DEFAULT
) (
    input logic               Clock,
    input logic               Reset,
    data_mem_arbiter_if.slave bus
);

    arb_state_t    state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic          req0, req1, any_req, winner, win_wr;
    logic [AW-1:0] win_addr, own_addr;
    logic [DW-1:0] win_wdata;

    assign req0 = bus.Rd0 | bus.Wr0;
    assign req1 = bus.Rd1 | bus.Wr1;

    arb_pick u_pick (
        .req0   (req0),
        .req1   (req1),
        .last   (last_q),
        .any    (any_req),
        .winner (winner)
    );

    // Write wins over read when both strobes are raised on one port.
    assign win_wr    = winner ? bus.Wr1     : bus.Wr0;
    assign win_addr  = winner ? bus.Addr1   : bus.Addr0;
    assign win_wdata = winner ? bus.WrData1 : bus.WrData0;
    assign own_addr  = owner_q ? bus.Addr1  : bus.Addr0;

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_d        = last_q;
        bus.MemAddr   = bus.Addr0;
        bus.MemWrData = bus.WrData0;
        bus.MemWren   = 1'b0;
        bus.Waitreq0  = req0;
        bus.Waitreq1  = req1;
        bus.RdData0   = '0;
        bus.RdData1   = '0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    last_d        = winner;
                    bus.MemAddr   = win_addr;
                    bus.MemWrData = win_wdata;
                    if (win_wr) begin
                        bus.MemWren = 1'b1;
                        if (winner == PORT_AUX) bus.Waitreq1 = 1'b0;
                        else                    bus.Waitreq0 = 1'b0;
                    end else begin
                        owner_d = winner;
                        state_d = RD;
                    end
                end
            end
            RD: begin
                // Address held so the memory output stays tied to the owner's request.
                bus.MemAddr = own_addr;
                state_d     = IDLE;
                if (owner_q == PORT_AUX) begin
                    bus.Waitreq1 = 1'b0;
                    bus.RdData1  = bus.MemRdData;
                end else begin
                    bus.Waitreq0 = 1'b0;
                    bus.RdData0  = bus.MemRdData;
                end
            end
            default: state_d = IDLE;
        endcase
        if (Reset) begin
            bus.MemWren  = 1'b0;
            bus.Waitreq0 = 1'b1;
            bus.Waitreq1 = 1'b1;
            bus.RdData0  = '0;
            bus.RdData1  = '0;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            owner_q <= PORT_CPU;
            last_q  <= PORT_AUX;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed cases plus random two-port traffic
// checked cycle by cycle against a transaction-level model.
module tb_data_mem_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    always #5 Clock = ~Clock;

    data_mem_arbiter_if #(.DW(16), .AW(12)) bus ();

    data_mem_arbiter #(.DW(16), .AW(12)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    logic        p_rd   [2];
    logic        p_wr   [2];
    logic [11:0] p_addr [2];
    logic [15:0] p_wd   [2];

    assign bus.Rd0 = p_rd[0];
    assign bus.Wr0 = p_wr[0];
    assign bus.Addr0 = p_addr[0];
    assign bus.WrData0 = p_wd[0];
    assign bus.Rd1 = p_rd[1];
    assign bus.Wr1 = p_wr[1];
    assign bus.Addr1 = p_addr[1];
    assign bus.WrData1 = p_wd[1];

    function automatic logic [15:0] init_val(input logic [11:0] a);
        return 16'(32'h1111 * 32'(a));
    endfunction

    // Memory: registered read, contents default to init_val until written.
    logic [15:0] mem    [4096];
    bit          mem_wr [4096];
    always @(posedge Clock) begin
        if (bus.MemWren) begin
            mem[bus.MemAddr]    <= bus.MemWrData;
            mem_wr[bus.MemAddr] <= 1'b1;
        end
        bus.MemRdData <= mem_wr[bus.MemAddr] ? mem[bus.MemAddr] : init_val(bus.MemAddr);
    end

    // Reference model state (transaction level).
    logic [15:0] ref_mem [4096];
    bit          ref_wr  [4096];
    bit          m_busy;
    int          m_owner;
    int          m_last;
    bit          done     [2];
    bit          obs_done [2];
    logic [15:0] obs_rd   [2];
    int          n_pass, n_fail, n_total;

    function automatic logic [15:0] rmem(input logic [11:0] a);
        return ref_wr[a] ? ref_mem[a] : init_val(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: compare DUT outputs against the model at the falling edge, then advance.
    task automatic step(input string tag);
        bit          req[2];
        bit          e_wait[2];
        logic [15:0] e_rd[2];
        bit          e_wren, n_busy, do_wr;
        int          win, n_owner, n_last;
        logic [11:0] e_addr, wa;
        logic [15:0] wd;
        @(negedge Clock);
        for (int p = 0; p < 2; p++) begin
            req[p]    = p_rd[p] | p_wr[p];
            e_wait[p] = req[p];
            e_rd[p]   = '0;
        end
        e_wren = 1'b0; do_wr = 1'b0; wa = '0; wd = '0;
        n_busy = m_busy; n_owner = m_owner; n_last = m_last;
        e_addr = p_addr[0];
        if (Reset) begin
            e_wait[0] = 1'b1; e_wait[1] = 1'b1;
            n_busy = 1'b0; n_owner = 0; n_last = 1;
        end else if (m_busy) begin
            e_wait[m_owner] = 1'b0;
            e_rd[m_owner]   = rmem(p_addr[m_owner]);
            e_addr          = p_addr[m_owner];
            n_busy          = 1'b0;
        end else if (req[0] || req[1]) begin
            if (req[0] && req[1]) win = RR ? 1 - m_last : 0;
            else                  win = req[1] ? 1 : 0;
            n_last = win;
            e_addr = p_addr[win];
            if (p_wr[win]) begin
                e_wren = 1'b1; e_wait[win] = 1'b0;
                do_wr = 1'b1; wa = p_addr[win]; wd = p_wd[win];
            end else begin
                n_busy = 1'b1; n_owner = win;
            end
        end
        chk($sformatf("%s.waitreq0", tag), 32'(bus.Waitreq0), 32'(e_wait[0]));
        chk($sformatf("%s.waitreq1", tag), 32'(bus.Waitreq1), 32'(e_wait[1]));
        chk($sformatf("%s.memwren", tag), 32'(bus.MemWren), 32'(e_wren));
        chk($sformatf("%s.rddata0", tag), 32'(bus.RdData0), 32'(e_rd[0]));
        chk($sformatf("%s.rddata1", tag), 32'(bus.RdData1), 32'(e_rd[1]));
        if (!Reset) chk($sformatf("%s.memaddr", tag), 32'(bus.MemAddr), 32'(e_addr));
        if (e_wren) chk($sformatf("%s.memwrdata", tag), 32'(bus.MemWrData), 32'(wd));
        for (int p = 0; p < 2; p++) begin
            done[p] = req[p] && !e_wait[p];
            obs_rd[p] = (p == 0) ? bus.RdData0 : bus.RdData1;
            obs_done[p] = req[p] && !((p == 0) ? bus.Waitreq0 : bus.Waitreq1);
        end
        @(posedge Clock);
        m_busy = n_busy; m_owner = n_owner; m_last = n_last;
        if (do_wr) begin
            ref_mem[wa] = wd;
            ref_wr[wa]  = 1'b1;
        end
        #1;
    endtask

    // Steps until every requesting port completes (as seen on the DUT) or the budget runs out.
    task automatic run_until_done(input string tag, output int t0, output int t1);
        t0 = (p_rd[0] | p_wr[0]) ? -1 : 0;
        t1 = (p_rd[1] | p_wr[1]) ? -1 : 0;
        for (int k = 0; k < 8 && (t0 < 0 || t1 < 0); k++) begin
            step(tag);
            if (obs_done[0] && t0 < 0) begin t0 = k; p_rd[0] = 1'b0; p_wr[0] = 1'b0; end
            if (obs_done[1] && t1 < 0) begin t1 = k; p_rd[1] = 1'b0; p_wr[1] = 1'b0; end
        end
    endtask

    task automatic set_req(input int p, input bit rd, input bit wr, input logic [11:0] a,
                           input logic [15:0] d);
        p_rd[p] = rd; p_wr[p] = wr; p_addr[p] = a; p_wd[p] = d;
    endtask

    task automatic do_reset(input string tag);
        Reset = 1'b1;
        step(tag);
        chk({tag, ".hold_waitreq0"}, 32'(bus.Waitreq0), 32'd1);
        chk({tag, ".hold_memwren"}, 32'(bus.MemWren), 32'd0);
        Reset = 1'b0;
    endtask

    initial begin
        int t0, t1, n1;
        n_pass = 0; n_fail = 0; n_total = 0;
        m_busy = 1'b0; m_owner = 0; m_last = 1;
        for (int p = 0; p < 2; p++) set_req(p, 1'b0, 1'b0, 12'h0, 16'h0);
        for (int a = 0; a < 4096; a++) begin ref_wr[a] = 1'b0; ref_mem[a] = '0; end

        do_reset("reset");

        // Uncontested writes, back to back.
        set_req(0, 1'b0, 1'b1, 12'h010, 16'hBEEF);
        step("wr0a");
        chk("wr0a.accepted", 32'(obs_done[0]), 32'd1);
        set_req(0, 1'b0, 1'b1, 12'h011, 16'hCAFE);
        step("wr0b");
        chk("wr0b.accepted", 32'(obs_done[0]), 32'd1);

        // Two-cycle read.
        set_req(0, 1'b1, 1'b0, 12'h010, 16'h0);
        step("rd0_c0");
        chk("rd0_c0.stall", 32'(obs_done[0]), 32'd0);
        step("rd0_c1");
        chk("rd0_c1.done", 32'(obs_done[0]), 32'd1);
        chk("rd0_c1.data", 32'(obs_rd[0]), 32'hBEEF);
        set_req(0, 1'b0, 1'b0, 12'h0, 16'h0);

        // Contest after reset: last=1, so port 0 first in either mode.
        do_reset("reset2");
        set_req(0, 1'b1, 1'b0, 12'h001, 16'h0);
        set_req(1, 1'b1, 1'b0, 12'h002, 16'h0);
        run_until_done("contest1", t0, t1);
        chk("contest1.t0", 32'(t0), 32'd1);
        chk("contest1.t1", 32'(t1), 32'd3);
        chk("contest1.data1", 32'(obs_rd[1]), 32'h2222);

        // Port 0 alone, then a repeated contest.
        set_req(0, 1'b0, 1'b1, 12'h020, 16'h0055);
        step("solo_wr0");
        set_req(0, 1'b0, 1'b0, 12'h0, 16'h0);
        set_req(0, 1'b1, 1'b0, 12'h001, 16'h0);
        set_req(1, 1'b1, 1'b0, 12'h002, 16'h0);
        run_until_done("contest2", t0, t1);
`ifdef ARB_ROUND_ROBIN_EN
        chk("contest2.t1_first", 32'(t1), 32'd1);
        chk("contest2.t0", 32'(t0), 32'd3);
`else
        chk("contest2.t0_first", 32'(t0), 32'd1);
        chk("contest2.t1", 32'(t1), 32'd3);
`endif

        // Continuous port 0 reads against a pending port 1 read.
        n1 = 0;
        set_req(0, 1'b1, 1'b0, 12'h003, 16'h0);
        set_req(1, 1'b1, 1'b0, 12'h002, 16'h0);
        for (int k = 0; k < 12; k++) begin
            step("stream");
            if (obs_done[1]) begin n1++; set_req(1, 1'b0, 1'b0, 12'h0, 16'h0); end
            if (done[0]) set_req(0, 1'b1, 1'b0, 12'($urandom_range(0, 15)), 16'h0);
        end
`ifdef ARB_ROUND_ROBIN_EN
        chk("stream.aux_served", 32'(n1), 32'd1);
`else
        chk("stream.aux_starved", 32'(n1), 32'd0);
`endif
        // Drain: finish any pending port 0 read and the port 1 read.
        if (!m_busy) set_req(0, 1'b0, 1'b0, 12'h0, 16'h0);
        run_until_done("drain", t0, t1);
        chk("drain.t1_bound", 32'(t1 >= 0), 32'd1);

        // Port 1 write contending with port 0 read of the same location.
        set_req(0, 1'b1, 1'b0, 12'h0F0, 16'h0);
        set_req(1, 1'b0, 1'b1, 12'h0F0, 16'h1234);
        run_until_done("wr_vs_rd", t0, t1);
        chk("wr_vs_rd.both", 32'(t0 >= 0 && t1 >= 0), 32'd1);
        set_req(0, 1'b1, 1'b0, 12'h0F0, 16'h0);
        run_until_done("rdback", t0, t1);
        chk("rdback.t0", 32'(t0), 32'd1);
        chk("rdback.data", 32'(obs_rd[0]), 32'h1234);

        // Reset in the read-data cycle abandons the read.
        set_req(0, 1'b1, 1'b0, 12'h010, 16'h0);
        step("rst_rd_grant");
        do_reset("rst_mid");
        run_until_done("rst_reread", t0, t1);
        chk("rst_reread.t0", 32'(t0), 32'd1);
        chk("rst_reread.data", 32'(obs_rd[0]), 32'hBEEF);

        // Random traffic on both ports over a small address window.
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (done[p] || !(p_rd[p] | p_wr[p])) begin
                    int unsigned r;
                    r = $urandom_range(0, 3);
                    set_req(p, r == 1 || r == 3, r >= 2, 12'($urandom_range(0, 15)),
                            16'($urandom));
                end
            end
            step("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

endmodule
